cnt_ser_bank: RTL

//  Counter-readout serializer downstream of the SPI slave. SPI addresses 4-59 drive

---
 rtl/psec5_pkg.sv | 9 +
 rtl/cnt_ser_shift.sv | 33 +++
 rtl/cnt_ser_bank.sv | 99 +++++++++
 3 files changed

// File: rtl/psec5_pkg.sv
// Shared sizing, idle encodings and FSM state type for the counter-readout serializer.
package psec5_pkg;
  localparam int NUM_CH  = 8;
  localparam int NUM_SEL = 7;
  localparam int BYTE_W  = 8;
  localparam logic [2:0] SEL_IDLE = 3'b111;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} ser_state_e;
endpackage

// File: rtl/cnt_ser_shift.sv
// Byte shift register (MSB out first) with a bit counter flagging the last bit.
module cnt_ser_shift #(
  parameter int BYTE_W = 8
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [BYTE_W-1:0] load_data,
  output logic              msb,
  output logic              last
);
  localparam int CNT_W = $clog2(BYTE_W);

  logic [BYTE_W-1:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt;

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (load) begin
      shift_reg <= load_data;
      bit_cnt   <= '0;
    end else if (shift) begin
      shift_reg <= {shift_reg[BYTE_W-2:0], 1'b0};
      bit_cnt   <= bit_cnt + 1'b1;
    end
  end

  assign msb  = shift_reg[BYTE_W-1];
  assign last = (bit_cnt == CNT_W'(BYTE_W-1));
endmodule

// File: rtl/cnt_ser_bank.sv
// Snapshots the one-hot selected channel's counter word and streams the selected
// byte MSB-first on sclk; consecutive bytes of the same channel are gapless.
module cnt_ser_bank #(
  parameter int NUM_CH  = psec5_pkg::NUM_CH,
  parameter int NUM_SEL = psec5_pkg::NUM_SEL,
  parameter int BYTE_W  = psec5_pkg::BYTE_W
) (
  input  logic                             sclk,
  input  logic                             rst,
  input  logic [NUM_CH-1:0]                load_cnt_ser,
  input  logic [2:0]                       select_reg,
  input  logic [NUM_CH*NUM_SEL*BYTE_W-1:0] cnt_data,
  output logic                             ser_out,
  output logic                             byte_start,
  output logic                             busy,
  output logic                             onehot_err
);
  import psec5_pkg::*;

  localparam int WORD_W = NUM_SEL * BYTE_W;
  localparam int OFF_W  = $clog2(WORD_W);

  ser_state_e        state;
  logic [WORD_W-1:0] shadow;
  logic [WORD_W-1:0] word_sel;
  logic [NUM_CH-1:0] ch_q;
  logic [OFF_W-1:0]  off;
  logic [BYTE_W-1:0] byte_sel;
  logic              onehot, multi, sel_ok, active, same_ch;
  logic              sh_load, sh_shift, sh_msb, sh_last;

  always_comb begin
    word_sel = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (load_cnt_ser[c]) word_sel |= cnt_data[c*WORD_W +: WORD_W];
  end

  assign onehot  = (load_cnt_ser != '0) && ((load_cnt_ser & (load_cnt_ser - 1'b1)) == '0);
  assign multi   = (load_cnt_ser != '0) && !onehot;
  assign sel_ok  = (select_reg != SEL_IDLE) && (int'(select_reg) < NUM_SEL);
  assign active  = onehot && sel_ok;
  assign same_ch = (load_cnt_ser == ch_q);

  // An out-of-range select during LOAD falls back to byte 0 rather than reading past the word.
  assign off      = sel_ok ? OFF_W'(select_reg) * OFF_W'(BYTE_W) : '0;
  assign byte_sel = shadow[off +: BYTE_W];

  assign sh_load  = (state == LOAD) || ((state == SHIFT) && sh_last && active && same_ch);
  assign sh_shift = (state == SHIFT) && !sh_load;

  cnt_ser_shift #(.BYTE_W(BYTE_W)) u_shift (
    .sclk      (sclk),
    .rst       (rst),
    .load      (sh_load),
    .shift     (sh_shift),
    .load_data (byte_sel),
    .msb       (sh_msb),
    .last      (sh_last)
  );

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shadow     <= '0;
      ch_q       <= '0;
      byte_start <= 1'b0;
      onehot_err <= 1'b0;
    end else begin
      byte_start <= 1'b0;
      if (multi) onehot_err <= 1'b1;
      case (state)
        IDLE: if (active) begin
          shadow <= word_sel;
          ch_q   <= load_cnt_ser;
          state  <= LOAD;
        end
        LOAD: begin
          byte_start <= 1'b1;
          state      <= SHIFT;
        end
        SHIFT: if (sh_last) begin
          if (active && same_ch) begin
            byte_start <= 1'b1;
          end else if (active) begin
            shadow <= word_sel;
            ch_q   <= load_cnt_ser;
            state  <= LOAD;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ser_out = (state == SHIFT) && sh_msb;
  assign busy    = (state != IDLE);
endmodule
